// File: rtl/controller_pkg.sv
// Shared types and index widths for the file-processing controller
// and the datapath it sequences.
package controller_pkg;

   localparam int FILE_W = 10;
   localparam int LINE_W = 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LOAD,
      S_WRITE,
      S_DONE
   } state_t;

endpackage

// File: rtl/controller_if.sv
// Control bundle between the controller (master) and the
// datapath/run requester (slave).
interface controller_if;
   import controller_pkg::*;

   logic              start;
   logic              read_file;
   logic              write_reg;
   logic              write_file;
   logic [FILE_W-1:0] file_index;
   logic [LINE_W-1:0] line_index;
   logic              busy;
   logic              done;

   modport master (
      input  start,
      output read_file,
      output write_reg,
      output write_file,
      output file_index,
      output line_index,
      output busy,
      output done
   );

   modport slave (
      output start,
      input  read_file,
      input  write_reg,
      input  write_file,
      input  file_index,
      input  line_index,
      input  busy,
      input  done
   );

endinterface

// File: rtl/controller_wrap_counter.sv
// Modulo counter with synchronous clear; last flags the top value.
module wrap_counter #(
   parameter int W   = 6,
   parameter int MOD = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         last
);

   localparam logic [W-1:0] MAXV = W'(MOD - 1);

   assign last = (count == MAXV);

   // clear wins over increment so a run always restarts at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= last ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/controller.sv
// Sequencing FSM: read, load and write back every line of every
// file, then pulse done. Owns only the indices and strobes.
module controller
   import controller_pkg::*;
#(
   parameter int NUM_FILES = 1024,
   parameter int NUM_LINES = 64
) (
   input logic          clk,
   input logic          rst,
   controller_if.master bus
);

   state_t state;
   state_t state_next;

   logic              line_last;
   logic              file_last;
   logic              run_clr;
   logic              line_inc;
   logic              file_inc;
   logic [FILE_W-1:0] file_count;
   logic [LINE_W-1:0] line_count;

   // counters clear on run start and on the final write
   assign run_clr  = (state == S_IDLE && bus.start) ||
                     (state == S_WRITE && line_last && file_last);
   assign line_inc = (state == S_WRITE);
   assign file_inc = line_inc && line_last;

   wrap_counter #(
      .W   (LINE_W),
      .MOD (NUM_LINES)
   ) u_line (
      .clk   (clk),
      .rst   (rst),
      .clr   (run_clr),
      .inc   (line_inc),
      .count (line_count),
      .last  (line_last)
   );

   wrap_counter #(
      .W   (FILE_W),
      .MOD (NUM_FILES)
   ) u_file (
      .clk   (clk),
      .rst   (rst),
      .clr   (run_clr),
      .inc   (file_inc),
      .count (file_count),
      .last  (file_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:  if (bus.start) state_next = S_READ;
         S_READ:  state_next = S_LOAD;
         S_LOAD:  state_next = S_WRITE;
         S_WRITE: begin
            if (line_last && file_last) begin
               state_next = S_DONE;
            end else begin
               state_next = S_READ;
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   assign bus.read_file  = (state == S_READ);
   assign bus.write_reg  = (state == S_LOAD);
   assign bus.write_file = (state == S_WRITE);
   assign bus.done       = (state == S_DONE);
   assign bus.busy       = (state == S_READ) ||
                           (state == S_LOAD) ||
                           (state == S_WRITE);
   assign bus.file_index = file_count;
   assign bus.line_index = line_count;

endmodule

// File: tb/tb_controller.sv
// Directed-vector bench for controller: a 2x3 instance and a 1x1 instance.
module tb_controller;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   controller_if bus_a ();
   controller_if bus_b ();

   controller #(
      .NUM_FILES (2),
      .NUM_LINES (3)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   controller #(
      .NUM_FILES (1),
      .NUM_LINES (1)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {read_file, write_reg, write_file, busy, done, file, line}
   function automatic logic [20:0] vec_a();
      return {bus_a.read_file, bus_a.write_reg, bus_a.write_file,
              bus_a.busy, bus_a.done, bus_a.file_index, bus_a.line_index};
   endfunction

   function automatic logic [20:0] vec_b();
      return {bus_b.read_file, bus_b.write_reg, bus_b.write_file,
              bus_b.busy, bus_b.done, bus_b.file_index, bus_b.line_index};
   endfunction

   // expected vector in cycle c after the start edge of a run
   function automatic logic [20:0] exp_vec(int c, int nf, int nl);
      int         n;
      int         idx;
      int         ph;
      logic       rf;
      logic       wr;
      logic       wf;
      logic       bz;
      logic       dn;
      logic [9:0] fi;
      logic [5:0] li;
      n  = nf * nl;
      rf = 1'b0;
      wr = 1'b0;
      wf = 1'b0;
      bz = 1'b0;
      dn = 1'b0;
      fi = '0;
      li = '0;
      if (c >= 1 && c <= 3 * n) begin
         idx = (c - 1) / 3;
         ph  = (c - 1) % 3;
         fi  = 10'(idx / nl);
         li  = 6'(idx % nl);
         rf  = (ph == 0);
         wr  = (ph == 1);
         wf  = (ph == 2);
         bz  = 1'b1;
      end else if (c == 3 * n + 1) begin
         dn = 1'b1;
      end
      return {rf, wr, wf, bz, dn, fi, li};
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   initial begin
      int reads;
      int busy_cnt;
      logic [20:0] v;

      total       = 0;
      bad         = 0;
      rst         = 1'b1;
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      @(negedge clk);
      chk("reset_a", 32'(vec_a()), 32'd0);
      chk("reset_b", 32'(vec_b()), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("idle_a%0d", i), 32'(vec_a()), 32'd0);
      end

      // run 1 with mid-run start pulse and start held across DONE
      reads = 0;
      bus_a.start = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= 41; c++) begin
         v = vec_a();
         chk($sformatf("run c=%0d", c), 32'(v),
             32'(exp_vec(c <= 20 ? c : c - 20, 2, 3)));
         chk($sformatf("excl c=%0d", c),
             32'($countones({v[20], v[19], v[18], v[16]}) <= 1), 32'd1);
         if (c <= 20 && v[20]) reads++;
         if (c == 1)  bus_a.start = 1'b0;
         if (c == 6)  bus_a.start = 1'b1;
         if (c == 7)  bus_a.start = 1'b0;
         if (c == 18) bus_a.start = 1'b1;
         if (c == 21) bus_a.start = 1'b0;
         @(negedge clk);
      end
      chk("read_count", 32'(reads), 32'd6);

      // reset asserted between edges during LOAD of (1,1)
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         chk($sformatf("pre_rst c=%0d", c), 32'(vec_a()),
             32'(exp_vec(c, 2, 3)));
         if (c < 14) @(negedge clk);
      end
      #2 rst = 1'b1;
      #1 chk("rst_async", 32'(vec_a()), 32'd0);
      @(negedge clk);
      chk("rst_hold", 32'(vec_a()), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_idle", 32'(vec_a()), 32'd0);
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         chk($sformatf("restart c=%0d", c), 32'(vec_a()),
             32'(exp_vec(c, 2, 3)));
         @(negedge clk);
      end

      // single file, single line
      busy_cnt = 0;
      bus_b.start = 1'b1;
      @(negedge clk);
      bus_b.start = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         v = vec_b();
         chk($sformatf("one c=%0d", c), 32'(v), 32'(exp_vec(c, 1, 1)));
         if (v[17]) busy_cnt++;
         @(negedge clk);
      end
      chk("one_busy", 32'(busy_cnt), 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
